// File: rtl/nios_bts_local_pkg.sv
// Shared types and helpers for the BTS local-interface memory responder.
package nios_bts_local_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN
  } state_e;

  localparam int unsigned BEAT_CNT_W   = 2;
  localparam int unsigned LOCAL_DATA_W = 128;
  localparam int unsigned LOCAL_BE_W   = LOCAL_DATA_W / 8;

  function automatic logic [LOCAL_DATA_W-1:0] be_to_mask(input logic [LOCAL_BE_W-1:0] be);
    logic [LOCAL_DATA_W-1:0] mask;
    for (int i = 0; i < LOCAL_BE_W; i++) mask[i*8 +: 8] = {8{be[i]}};
    return mask;
  endfunction

endpackage

// File: rtl/nios_bts_local_mem_ram.sv
// Simple dual-port byte-enabled RAM with a registered read port.
module nios_bts_local_mem_ram
  import nios_bts_local_pkg::*;
#(
  parameter int addr_width = 8
) (
  input  logic                    clk,
  input  logic                    we_i,
  input  logic [addr_width-1:0]   waddr_i,
  input  logic [LOCAL_DATA_W-1:0] wdata_i,
  input  logic [LOCAL_BE_W-1:0]   be_i,
  input  logic                    re_i,
  input  logic [addr_width-1:0]   raddr_i,
  output logic [LOCAL_DATA_W-1:0] rdata_o
);

  logic [LOCAL_DATA_W-1:0] mem_q [2**addr_width];
  logic [LOCAL_DATA_W-1:0] wmask;

  assign wmask = be_to_mask(be_i);

  // NOTE: storage and read register carry no reset so they map onto block RAM.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= (mem_q[waddr_i] & ~wmask) | (wdata_i & wmask);
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/nios_bts_local_mem_responder.sv
// DDR2-controller local-side emulation: init handshake, write-data request pacing,
// fixed-latency read return from a small on-chip RAM.
module nios_bts_local_mem_responder
  import nios_bts_local_pkg::*;
#(
  parameter int local_addr_width = 23,
  parameter int local_data_width = LOCAL_DATA_W,
  parameter int local_be_width   = LOCAL_BE_W,
  parameter int local_size_width = BEAT_CNT_W,
  parameter int mem_addr_width   = 8,
  parameter int read_latency     = 4,
  parameter int init_cycles      = 16
) (
  input  logic                        local_clk,
  input  logic                        reset_n,
  input  logic                        local_reset_n,
  input  logic [local_addr_width-1:0] local_addr,
  input  logic [local_be_width-1:0]   local_be,
  input  logic [local_data_width-1:0] local_wdata,
  input  logic                        local_read_req,
  input  logic                        local_write_req,
  input  logic [local_size_width-1:0] local_size,
  input  logic                        local_burst_begin,
  output logic                        local_ready,
  output logic                        local_init_done,
  output logic                        local_wdata_req,
  output logic [local_data_width-1:0] local_rdata,
  output logic                        local_rdata_valid,
  output logic                        local_rdvalid_in_n,
  input  logic                        inject_err,
  output logic                        protocol_err
);

  localparam int INIT_CNT_W = $clog2(init_cycles + 1);

  state_e                      state_q, state_d;
  logic [INIT_CNT_W-1:0]       init_cnt_q, init_cnt_d;
  logic [mem_addr_width-1:0]   addr_q, addr_d;
  logic [local_size_width-1:0] beats_q, beats_d;
  logic [local_size_width-1:0] req_cnt_q, req_cnt_d;  // write-data requests or read issues
  logic [local_size_width-1:0] wr_cnt_q, wr_cnt_d;    // write beats sampled
  logic                        err_q, err_d;
  logic                        sample_q;              // a write beat is on local_wdata this cycle
  logic [read_latency-1:0]     vld_q, inj_q;

  logic                        any_req, accept, wdata_req, rd_issue, wr_en;
  logic [mem_addr_width-1:0]   wr_addr, rd_addr;
  logic [local_data_width-1:0] ram_rdata, pipe_data;
  logic                        addr_unused;

  assign any_req     = local_read_req | local_write_req;
  assign accept      = (state_q == ST_IDLE) && any_req;
  assign wr_addr     = addr_q + mem_addr_width'(wr_cnt_q);
  assign rd_addr     = addr_q + mem_addr_width'(req_cnt_q);
  assign addr_unused = ^local_addr[local_addr_width-1:mem_addr_width];

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    addr_d     = addr_q;
    beats_d    = beats_q;
    req_cnt_d  = req_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    err_d      = err_q;
    wdata_req  = 1'b0;
    rd_issue   = 1'b0;
    wr_en      = 1'b0;

    if (any_req && state_q == ST_INIT) err_d = 1'b1;
    if (accept && ((local_read_req && local_write_req) || local_size == '0 || !local_burst_begin))
      err_d = 1'b1;

    unique case (state_q)
      ST_INIT: begin
        if (init_cnt_q == INIT_CNT_W'(init_cycles - 1)) state_d = ST_IDLE;
        else init_cnt_d = init_cnt_q + 1'b1;
      end
      ST_IDLE: begin
        if (accept) begin
          addr_d    = local_addr[mem_addr_width-1:0];
          beats_d   = (local_size == '0) ? local_size_width'(1) : local_size;
          req_cnt_d = '0;
          wr_cnt_d  = '0;
          state_d   = local_write_req ? ST_WRITE : ST_READ;
        end
      end
      ST_WRITE: begin
        wdata_req = (req_cnt_q != beats_q);
        if (wdata_req) req_cnt_d = req_cnt_q + 1'b1;
        if (sample_q) begin
          wr_en    = 1'b1;
          wr_cnt_d = wr_cnt_q + 1'b1;
          if (wr_cnt_q == beats_q - local_size_width'(1)) state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        rd_issue  = 1'b1;
        req_cnt_d = req_cnt_q + 1'b1;
        if (req_cnt_q == beats_q - local_size_width'(1)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (vld_q == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge local_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      addr_q     <= '0;
      beats_q    <= '0;
      req_cnt_q  <= '0;
      wr_cnt_q   <= '0;
      err_q      <= 1'b0;
      sample_q   <= 1'b0;
      vld_q      <= '0;
      inj_q      <= '0;
    end else if (!local_reset_n) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      addr_q     <= '0;
      beats_q    <= '0;
      req_cnt_q  <= '0;
      wr_cnt_q   <= '0;
      err_q      <= 1'b0;
      sample_q   <= 1'b0;
      vld_q      <= '0;
      inj_q      <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      addr_q     <= addr_d;
      beats_q    <= beats_d;
      req_cnt_q  <= req_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      err_q      <= err_d;
      sample_q   <= wdata_req;
      vld_q[0]   <= rd_issue;
      inj_q[0]   <= rd_issue & inject_err;
      for (int i = 1; i < read_latency; i++) begin
        vld_q[i] <= vld_q[i-1];
        inj_q[i] <= inj_q[i-1];
      end
    end
  end

  nios_bts_local_mem_ram #(
    .addr_width (mem_addr_width)
  ) u_ram (
    .clk     (local_clk),
    .we_i    (wr_en),
    .waddr_i (wr_addr),
    .wdata_i (local_wdata),
    .be_i    (local_be),
    .re_i    (rd_issue),
    .raddr_i (rd_addr),
    .rdata_o (ram_rdata)
  );

  // The RAM read register is the first latency stage; data stages are unreset
  // because the output is gated by the reset valid chain.
  generate
    if (read_latency > 1) begin : g_data_pipe
      logic [local_data_width-1:0] data_q [read_latency-1];
      always_ff @(posedge local_clk) begin
        data_q[0] <= ram_rdata;
        for (int i = 1; i < read_latency - 1; i++) data_q[i] <= data_q[i-1];
      end
      assign pipe_data = data_q[read_latency-2];
    end else begin : g_no_pipe
      assign pipe_data = ram_rdata;
    end
  endgenerate

  assign local_ready        = (state_q == ST_IDLE);
  assign local_init_done    = (state_q != ST_INIT);
  assign local_wdata_req    = wdata_req;
  assign local_rdata_valid  = vld_q[read_latency-1];
  assign local_rdvalid_in_n = ~vld_q[read_latency-1];
  assign local_rdata        = local_rdata_valid
                            ? (pipe_data ^ {{(local_data_width-1){1'b0}}, inj_q[read_latency-1]})
                            : '0;
  assign protocol_err       = err_q;

endmodule

// File: tb/tb_nios_bts_local_mem_responder.sv
// Directed bench for the BTS local-interface memory responder.
module tb_nios_bts_local_mem_responder;

  logic         local_clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         local_reset_n = 1'b1;
  logic [22:0]  local_addr = '0;
  logic [15:0]  local_be = '0;
  logic [127:0] local_wdata = '0;
  logic         local_read_req = 1'b0;
  logic         local_write_req = 1'b0;
  logic [1:0]   local_size = '0;
  logic         local_burst_begin = 1'b0;
  logic         local_ready, local_init_done, local_wdata_req;
  logic [127:0] local_rdata;
  logic         local_rdata_valid, local_rdvalid_in_n;
  logic         inject_err = 1'b0;
  logic         protocol_err;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [127:0] D0   = 128'h0123456789ABCDEF_FEDCBA9876543210;
  localparam logic [127:0] DA   = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] DB   = 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000;
  localparam logic [127:0] DC   = 128'h0C0C_0C0C_0C0C_0C0C_0C0C_0C0C_0C0C_0C0C;
  localparam logic [127:0] DE   = 128'hEEEE_0000_EEEE_0000_EEEE_0000_EEEE_0001;
  localparam logic [127:0] ONES = {128{1'b1}};
  localparam logic [127:0] BEX  = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FF00;
  localparam logic [127:0] D0I  = 128'h0123456789ABCDEF_FEDCBA9876543211;

  always #5 local_clk = ~local_clk;

  nios_bts_local_mem_responder dut (
    .local_clk          (local_clk),
    .reset_n            (reset_n),
    .local_reset_n      (local_reset_n),
    .local_addr         (local_addr),
    .local_be           (local_be),
    .local_wdata        (local_wdata),
    .local_read_req     (local_read_req),
    .local_write_req    (local_write_req),
    .local_size         (local_size),
    .local_burst_begin  (local_burst_begin),
    .local_ready        (local_ready),
    .local_init_done    (local_init_done),
    .local_wdata_req    (local_wdata_req),
    .local_rdata        (local_rdata),
    .local_rdata_valid  (local_rdata_valid),
    .local_rdvalid_in_n (local_rdvalid_in_n),
    .inject_err         (inject_err),
    .protocol_err       (protocol_err)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge local_clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!local_ready && n < 64) begin
      tick();
      n++;
    end
    check({tag, "_ready"}, local_ready, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"},       local_ready, 0);
    check({tag, "_init_done"},   local_init_done, 0);
    check({tag, "_wdata_req"},   local_wdata_req, 0);
    check({tag, "_rdata_valid"}, local_rdata_valid, 0);
    check({tag, "_rdvalid_n"},   local_rdvalid_in_n, 1);
    check({tag, "_rdata"},       local_rdata, '0);
    check({tag, "_perr"},        protocol_err, 0);
  endtask

  task automatic do_write(input logic [22:0] addr, input logic [1:0] size, input int beats,
                          input logic [127:0] d0, input logic [127:0] d1,
                          input logic [15:0] b0, input logic [15:0] b1,
                          input bit both, input bit bb, input string tag);
    int pulses = 0;
    wait_ready(tag);
    local_addr        = addr;
    local_size        = size;
    local_burst_begin = bb;
    local_write_req   = 1'b1;
    local_read_req    = both;
    tick();
    local_write_req   = 1'b0;
    local_read_req    = 1'b0;
    local_burst_begin = 1'b0;
    for (int c = 0; c <= beats; c++) begin
      if (c == 1) begin local_wdata = d0; local_be = b0; end
      if (c == 2) begin local_wdata = d1; local_be = b1; end
      if (local_wdata_req) pulses++;
      tick();
    end
    local_wdata = '0;
    local_be    = '0;
    check({tag, "_wdata_req_beats"}, pulses, beats);
    check({tag, "_ready_after"}, local_ready, 1);
  endtask

  task automatic do_read(input logic [22:0] addr, input logic [1:0] size, input int beats,
                         input logic [127:0] e0, input logic [127:0] e1, input string tag);
    int got = 0;
    int first = -1;
    int second = -1;
    int bad_n = 0;
    logic [127:0] r0 = '0;
    logic [127:0] r1 = '0;
    wait_ready(tag);
    local_addr        = addr;
    local_size        = size;
    local_burst_begin = 1'b1;
    local_read_req    = 1'b1;
    tick();
    local_read_req    = 1'b0;
    local_burst_begin = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      if (local_rdvalid_in_n !== ~local_rdata_valid) bad_n++;
      if (local_rdata_valid) begin
        if (got == 0) begin first = n; r0 = local_rdata; end
        else if (got == 1) begin second = n; r1 = local_rdata; end
        got++;
      end
      tick();
    end
    check({tag, "_latency"}, first, 5);
    check({tag, "_beats"}, got, beats);
    check({tag, "_data0"}, r0, e0);
    check({tag, "_rdvalid_n"}, bad_n, 0);
    if (beats > 1) begin
      check({tag, "_data1"}, r1, e1);
      check({tag, "_consecutive"}, second, first + 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    int early;
    int bad_n;

    // Reset state and init handshake
    repeat (3) tick();
    check_reset_outputs("reset");
    @(negedge local_clk);
    reset_n = 1'b1;
    n = 0; early = 0; bad_n = 0;
    while (!local_init_done && n < 40) begin
      if (local_ready) early++;
      if (!local_rdvalid_in_n) bad_n++;
      tick();
      n++;
    end
    check("init_cycles", n, 16);
    check("init_ready_early", early, 0);
    check("init_rdvalid_n", bad_n, 0);
    check("init_ready", local_ready, 1);

    // Single write then read, plus upper address bits ignored
    do_write(23'h05, 2'd1, 1, D0, '0, 16'hFFFF, '0, 1'b0, 1'b1, "wr_single");
    do_read(23'h05, 2'd1, 1, D0, '0, "rd_single");
    do_read(23'h12_3405, 2'd1, 1, D0, '0, "rd_upper_addr");

    // Burst wrapping past the top of the RAM
    do_write(23'hFF, 2'd2, 2, DA, DB, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, "wr_wrap");
    do_read(23'hFF, 2'd2, 2, DA, DB, "rd_wrap");
    do_read(23'h00, 2'd1, 1, DB, '0, "rd_wrap_lo");

    // Byte enables
    do_write(23'h10, 2'd1, 1, ONES, '0, 16'hFFFF, '0, 1'b0, 1'b1, "wr_be_pre");
    do_write(23'h10, 2'd1, 1, '0, '0, 16'h0001, '0, 1'b0, 1'b1, "wr_be");
    do_read(23'h10, 2'd1, 1, BEX, '0, "rd_be");

    // Error injection on the read path
    inject_err = 1'b1;
    do_read(23'h05, 2'd1, 1, D0I, '0, "rd_inject");
    inject_err = 1'b0;
    check("perr_clean", protocol_err, 0);

    // Simultaneous read and write: write wins, error flagged
    do_write(23'h20, 2'd1, 1, DC, '0, 16'hFFFF, '0, 1'b1, 1'b1, "wr_both");
    check("perr_both", protocol_err, 1);
    do_read(23'h20, 2'd1, 1, DC, '0, "rd_both");

    // Zero size treated as one beat
    do_write(23'h30, 2'd0, 1, DE, '0, 16'hFFFF, '0, 1'b0, 1'b1, "wr_size0");
    do_read(23'h30, 2'd0, 1, DE, '0, "rd_size0");
    check("perr_size0", protocol_err, 1);

    // Soft reset while the read pipeline drains
    wait_ready("soft");
    local_addr = 23'h05; local_size = 2'd3; local_burst_begin = 1'b1; local_read_req = 1'b1;
    tick();
    local_read_req = 1'b0; local_burst_begin = 1'b0;
    repeat (3) tick();
    local_reset_n = 1'b0;
    tick();
    local_reset_n = 1'b1;
    check_reset_outputs("soft_rst");
    do_read(23'h05, 2'd1, 1, D0, '0, "rd_after_soft");
    do_read(23'hFF, 2'd2, 2, DA, DB, "rd_wrap_after_soft");
    check("perr_after_soft", protocol_err, 0);

    // Missing burst_begin
    do_write(23'h41, 2'd1, 1, DC, '0, 16'hFFFF, '0, 1'b0, 1'b0, "wr_nobb");
    check("perr_nobb", protocol_err, 1);

    // Hard reset in the middle of a write burst
    wait_ready("hard");
    local_addr = 23'h40; local_size = 2'd3; local_burst_begin = 1'b1; local_write_req = 1'b1;
    tick();
    local_write_req = 1'b0; local_burst_begin = 1'b0;
    tick();
    check("hard_wdata_req_pre", local_wdata_req, 1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("hard_rst");
    repeat (2) tick();
    @(negedge local_clk);
    reset_n = 1'b1;
    tick();

    // Request during init is an error and is not accepted
    local_read_req = 1'b1; local_burst_begin = 1'b1; local_size = 2'd1;
    tick();
    local_read_req = 1'b0; local_burst_begin = 1'b0;
    check("perr_init_req", protocol_err, 1);
    check("init_req_ignored", local_init_done, 0);
    do_read(23'h05, 2'd1, 1, D0, '0, "rd_after_hard");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
